// File: rtl/uart_rx_ctrl_if.sv
// Host read port of the RX buffer: head word plus valid/ready handshake.
interface uart_rx_ctrl_if;
    logic       rd_valid;
    logic       rd_ready;
    logic [8:0] rd_data;
    logic [1:0] rd_err;

    modport master (output rd_valid, output rd_data, output rd_err, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_err, output rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: between-frame config apply, frame buffer (fall-through read), sticky errors, irqs.
// Head word visible the cycle after push; a push to a full buffer without a pop is dropped as overrun.
module uart_rx_ctrl #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TO_BITS = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_wr,
    input  logic          cfg_rx_en,
    input  logic [1:0]    cfg_parity,
    input  logic [2:0]    cfg_data_bits,
    input  logic          cfg_stop_bit,
    input  logic [15:0]   cfg_divisor,
    input  logic          cfg_fifo_en,
    input  logic [AW:0]   cfg_thresh,
    output logic          cfg_busy,
    output logic          rx_en,
    output logic [1:0]    parity,
    output logic [2:0]    data_bits,
    output logic          stop_bit,
    output logic [15:0]   rx_divisor,
    output logic          fifo_en,
    output logic          fifo_full,
    output logic          rx_data_read,
    input  logic          rx_done,
    input  logic          rx_success,
    input  logic [8:0]    rx_data,
    input  logic [2:0]    rx_error,
    input  logic          rx_idle,
    uart_rx_ctrl_if.master rd,
    input  logic          flush,
    input  logic [2:0]    err_clr,
    output logic [2:0]    sts_err,
    output logic [AW:0]   level,
    output logic          irq_rx,
    output logic          irq_timeout,
    output logic          irq_err
);
    typedef struct packed {
        logic          rx_en;
        logic [1:0]    parity;
        logic [2:0]    data_bits;
        logic          stop_bit;
        logic [15:0]   divisor;
        logic          fifo_en;
        logic [AW:0]   thresh;
    } cfg_t;

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_APPLY} cstate_t;

    localparam cfg_t CFG_RST = {1'b0, 2'b00, 3'b011, 1'b0, 16'd5208, 1'b1, (AW+1)'(1)};
    localparam logic [AW:0] CAP_DEPTH = (AW+1)'(DEPTH);
    localparam int TW = $clog2(TO_BITS + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TO_BITS);

    cstate_t state, state_nxt;
    cfg_t    cfg_in, shadow, active;
    logic    apply, busy_q;

    assign cfg_in = {cfg_rx_en, cfg_parity, cfg_data_bits, cfg_stop_bit,
                     cfg_divisor, cfg_fifo_en, cfg_thresh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= C_IDLE;
            shadow <= CFG_RST;
            active <= CFG_RST;
            busy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_wr) begin
                shadow <= cfg_in;
                busy_q <= 1'b1;
            end else if (apply) begin
                busy_q <= 1'b0;
            end
            if (apply) active <= shadow;
        end
    end

    // A new write always restarts the wait; a disabled receiver need not reach idle.
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        if (cfg_wr) begin
            state_nxt = C_PEND;
        end else begin
            case (state)
                C_PEND:  if (rx_idle || !shadow.rx_en) state_nxt = C_APPLY;
                C_APPLY: begin
                    apply     = 1'b1;
                    state_nxt = C_IDLE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    logic [10:0]   mem [DEPTH];
    logic [10:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, cap, thr_eff;
    logic          full, push_req, pop, do_flush, push_ok, drop;

    assign cap      = active.fifo_en ? CAP_DEPTH : (AW+1)'(1);
    assign full     = (count == cap);
    assign push_req = rx_done & active.rx_en;
    assign pop      = (count != '0) & rd.rd_ready;
    assign do_flush = flush | (apply & (shadow.fifo_en != active.fifo_en));
    assign push_ok  = push_req & (~full | pop) & ~do_flush;
    assign drop     = push_req & full & ~pop & ~do_flush;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {rx_error[2], ~rx_success, rx_data};
    end

    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push_ok) count <= count - (AW+1)'(1);
        end
    end

    logic [2:0] err_set;
    assign err_set = {push_req & rx_error[2],
                      push_req & (~rx_success | rx_error[1]),
                      (push_req & rx_error[0]) | drop};

    always_ff @(posedge clk) begin
        if (rst) sts_err <= '0;
        else     sts_err <= (sts_err & ~err_clr) | err_set;
    end

    logic [15:0]   presc, div_m1;
    logic [TW-1:0] to_cnt;
    logic          tick, to_clr, to_inc;

    assign div_m1  = (active.divisor == 16'd0) ? 16'd0 : active.divisor - 16'd1;
    assign tick    = (presc >= div_m1);
    assign thr_eff = (active.thresh == '0) ? (AW+1)'(1) : active.thresh;
    assign to_clr  = push_req | pop | do_flush;
    // Only a partially filled buffer that the level irq will never report can time out.
    assign to_inc  = tick & (count != '0) & (count < thr_eff) & rx_idle & (to_cnt != TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            to_cnt      <= '0;
            irq_timeout <= 1'b0;
            irq_rx      <= 1'b0;
            irq_err     <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (to_clr)      to_cnt <= '0;
            else if (to_inc) to_cnt <= to_cnt + TW'(1);
            if (to_clr)                irq_timeout <= 1'b0;
            else if (to_cnt == TO_MAX) irq_timeout <= 1'b1;
            irq_rx  <= (count >= thr_eff);
            irq_err <= |sts_err;
        end
    end

    assign head        = mem[rd_ptr];
    assign rd.rd_valid = (count != '0);
    assign rd.rd_data  = head[8:0];
    assign rd.rd_err   = head[10:9];

    assign cfg_busy     = busy_q;
    assign rx_en        = active.rx_en;
    assign parity       = active.parity;
    assign data_bits    = active.data_bits;
    assign stop_bit     = active.stop_bit;
    assign rx_divisor   = active.divisor;
    assign fifo_en      = active.fifo_en;
    assign fifo_full    = full;
    assign rx_data_read = (count == '0);
    assign level        = count;
endmodule
